cpu_output_uart_tx: RTL and testbench

- Consumer end of the multicycle core's output port: accepts each word the core presents on `data_out` while `output_en` is high.
- Buffers accepted words in a FIFO and serializes each one over a UART 8N1 line, least-significant byte first.
- Sits beside the core at SoC top level.
- `out_ready` lets the controller stall output instructions while the FIFO is full.

---
 rtl/cpu_output_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_cpu_output_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_output_uart_tx.sv
// Output-port consumer for the multicycle core: buffers words in a FIFO and
// sends each one over a UART 8N1 line, least-significant byte first.
//
// state   | meaning
// S_IDLE  | line high, waiting for a buffered word to pop
// S_START | start bit (low) for one bit period
// S_DATA  | 8 data bits of the current byte, LSB first
// S_STOP  | stop bit (high); then next byte or back to idle
module cpu_output_uart_tx #(
    parameter int WORD_SIZE    = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          output_en,
    input  logic [WORD_SIZE-1:0]          data_out,
    output logic                          out_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int NB = WORD_SIZE / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 full, push, pop;

    state_t               state_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [BW-1:0]        byte_idx_q;
    logic [WORD_SIZE-1:0] shift_q;
    logic                 tx_q;
    logic                 busy_q;
    logic [7:0]           cur_byte;
    logic [2:0]           next_idx;

    assign full     = (count_q == DEPTH);
    assign push     = output_en && !full;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign cur_byte = shift_q[7:0];
    assign next_idx = bit_idx_q + 3'd1;

    // A word offered while full is dropped even if a pop frees space on the same edge.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        if (output_en && full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q    <= mem_q[rd_ptr_q];
                        state_q    <= S_START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                    end
                end
                S_START: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= cur_byte[0];
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= next_idx;
                            tx_q      <= cur_byte[next_idx];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        if (byte_idx_q != BYTE_LAST) begin
                            // Next byte follows immediately with no idle gap.
                            byte_idx_q <= byte_idx_q + 1'b1;
                            shift_q    <= shift_q >> 8;
                            state_q    <= S_START;
                            tx_q       <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_ready  = !full;
    assign fifo_count = count_q;
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_output_uart_tx.sv
// Randomized bench for cpu_output_uart_tx: a queue-and-timeline model predicts
// the FIFO occupancy and the exact serial waveform every cycle.
module tb_cpu_output_uart_tx;

    localparam int WS    = 32;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
    localparam int NB    = WS / 8;
    localparam int TOTAL = NB * 10 * CPB;

    logic          clk;
    logic          rst;
    logic          output_en;
    logic [WS-1:0] data_out;
    logic          out_ready;
    logic          tx;
    logic          tx_busy;
    logic          overflow;
    logic [3:0]    fifo_count;

    int checks   = 0;
    int failures = 0;

    // Model: words waiting, the word on the line and cycles of it left to send.
    logic [WS-1:0] mq[$];
    logic [WS-1:0] cur_word;
    int            busy_left;
    bit            ovf;

    cpu_output_uart_tx #(
        .WORD_SIZE(WS),
        .FIFO_DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .output_en(output_en),
        .data_out(data_out),
        .out_ready(out_ready),
        .tx(tx),
        .tx_busy(tx_busy),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int pos, slot, b, byt;
        logic [WS-1:0] w;
        if (busy_left == 0) return 1'b1;
        pos  = TOTAL - busy_left;
        slot = pos / CPB;
        b    = slot % 10;
        byt  = slot / 10;
        w    = cur_word;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return w[byt*8 + b - 1];
    endfunction

    task automatic model_reset();
        mq.delete();
        busy_left = 0;
        cur_word  = '0;
        ovf       = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [WS-1:0] d);
        int pre;
        pre = mq.size();
        if (busy_left > 0)
            busy_left--;
        else if (pre > 0) begin
            cur_word  = mq.pop_front();
            busy_left = TOTAL;
        end
        if (en) begin
            if (pre < DEPTH) mq.push_back(d);
            else ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_val("tx", {31'd0, tx}, {31'd0, exp_tx()});
        check_val("tx_busy", {31'd0, tx_busy}, (busy_left > 0) ? 32'd1 : 32'd0);
        check_val("fifo_count", {28'd0, fifo_count}, 32'(mq.size()));
        check_val("out_ready", {31'd0, out_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
        check_val("overflow", {31'd0, overflow}, {31'd0, ovf});
    endtask

    task automatic cycle(input logic en, input logic [WS-1:0] d);
        output_en = en;
        data_out  = d;
        @(posedge clk);
        model_edge(en, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy_left > 0 || mq.size() > 0) && n < 20000) begin
            cycle(1'b0, '0);
            n++;
        end
        repeat (3) cycle(1'b0, '0);
    endtask

    task automatic do_reset();
        #2;
        rst       = 1'b1;
        output_en = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        int n_busy, pushed, n;
        bit hit;
        rst       = 1'b1;
        output_en = 1'b0;
        data_out  = '0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Single word: busy exactly one word time
        n_busy = 0;
        cycle(1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, '0);
            if (tx_busy === 1'b1) n_busy++;
        end
        check_val("busy_cycles", 32'(n_busy), 32'd160);

        // Wrap-around: 20 words, pushed only when there is room
        pushed = 0;
        n      = 0;
        while (pushed < 20 && n < 10000) begin
            if (mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                cycle(1'b1, $urandom);
                pushed++;
            end else begin
                cycle(1'b0, '0);
            end
            n++;
        end
        drain();
        check_val("wrap_overflow", {31'd0, overflow}, 32'd0);
        check_val("wrap_count", {28'd0, fifo_count}, 32'd0);

        // Simultaneous push and pop with three words queued
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom);
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (busy_left == 0 && mq.size() == 3) hit = 1'b1;
            else cycle(1'b0, '0);
        end
        check_val("pushpop_reached", {31'd0, hit}, 32'd1);
        cycle(1'b1, 32'hA5A5_0F0F);
        check_val("pushpop_count", {28'd0, fifo_count}, 32'd3);
        check_val("pushpop_tx_low", {31'd0, tx}, 32'd0);
        drain();

        // Back-to-back fill: ten words offered, the tenth dropped
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'h1000_0000 + 32'(i * 32'h0101_0101));
        check_val("fill_count", {28'd0, fifo_count}, 32'd8);
        check_val("fill_ready", {31'd0, out_ready}, 32'd0);
        cycle(1'b1, 32'hBAD0_BAD0);
        check_val("fill_overflow", {31'd0, overflow}, 32'd1);
        drain();

        // Reset in the middle of byte 2 data with four words queued
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom);
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (busy_left > 0 && (TOTAL - busy_left) == (23 * CPB + 1)) hit = 1'b1;
            else cycle(1'b0, '0);
        end
        check_val("midframe_reached", {31'd0, hit}, 32'd1);
        check_val("midframe_queued", {28'd0, fifo_count}, 32'd4);
        do_reset();
        cycle(1'b1, 32'h0000_0055);
        drain();

        // Random traffic, overflow allowed
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 2) cycle(1'b1, $urandom);
            else cycle(1'b0, '0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
